// File: rtl/regfile_wb_pkg.sv
// Package: regfile_wb_pkg
// Shared types for the write-back stage that feeds the register file.
//  - wb_state_t : load tracking state (idle / one load outstanding)
//  - wb_sel_t   : which producer owns the register-file write port this cycle
//  - ptr_width  : safe pointer width for a FIFO of a given depth (never 0)
package regfile_wb_pkg;

  typedef enum logic {WB_IDLE, WB_LOAD_PEND} wb_state_t;

  typedef enum logic [1:0] {SEL_NONE, SEL_MEM, SEL_QUEUE, SEL_ALU} wb_sel_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Interface: regfile_writeback_if
// Bundles every non-clock/reset signal of the write-back stage.
//  master : producers, decode and register file side (drives requests, reads results)
//  slave  : the write-back stage itself
//  ALU    : AluValid/AluAddr/AluData in, AluReady out
//  Load   : LdIssue/LdDest in, LdIssueReady out; MemValid/MemData return path
//  Hazard : RaddrA/RaddrB in, Stall out
//  RegFile: WriteEn/Waddr/DataIn out (registered)
interface regfile_writeback_if #(
  parameter int W = 8,
  parameter int A = 2
);
  logic         AluValid;
  logic [A-1:0] AluAddr;
  logic [W-1:0] AluData;
  logic         AluReady;
  logic         LdIssue;
  logic [A-1:0] LdDest;
  logic         LdIssueReady;
  logic         MemValid;
  logic [W-1:0] MemData;
  logic [A-1:0] RaddrA;
  logic [A-1:0] RaddrB;
  logic         Stall;
  logic         WriteEn;
  logic [A-1:0] Waddr;
  logic [W-1:0] DataIn;

  modport master (
    output AluValid, AluAddr, AluData, LdIssue, LdDest, MemValid, MemData, RaddrA, RaddrB,
    input  AluReady, LdIssueReady, Stall, WriteEn, Waddr, DataIn
  );

  modport slave (
    input  AluValid, AluAddr, AluData, LdIssue, LdDest, MemValid, MemData, RaddrA, RaddrB,
    output AluReady, LdIssueReady, Stall, WriteEn, Waddr, DataIn
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Module: wb_queue
// Small {addr,data} FIFO holding ALU results that lost the write port to a
// load return. Head is read combinationally so it can be selected the same
// cycle it is popped.
//  clk, rst_n              : clock, asynchronous active-low reset
//  push/push_addr/push_data: enqueue (caller guarantees not full)
//  pop                     : dequeue head (caller guarantees not empty)
//  head_addr/head_data     : current head entry
//  count                   : registered occupancy
//  entry_addr/entry_valid  : every slot, for the decode hazard compare
module wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int W     = 8,
  parameter int A     = 2,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [A-1:0]            push_addr,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [A-1:0]            head_addr,
  output logic [W-1:0]            head_data,
  output logic [CW-1:0]           count,
  output logic [DEPTH-1:0][A-1:0] entry_addr,
  output logic [DEPTH-1:0]        entry_valid
);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [A-1:0]   addr_mem [DEPTH];
  logic [W-1:0]   data_mem [DEPTH];

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      // Push and pop never target the same slot: pop needs count>0 and
      // push needs count<DEPTH, so the pointers differ whenever both fire.
      if (push) begin
        wr_ptr_reg            <= next_ptr(wr_ptr_reg);
        valid_reg[wr_ptr_reg] <= 1'b1;
      end
      if (pop) begin
        rd_ptr_reg            <= next_ptr(rd_ptr_reg);
        valid_reg[rd_ptr_reg] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; valid_reg qualifies every slot.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head_addr   = addr_mem[rd_ptr_reg];
  assign head_data   = data_mem[rd_ptr_reg];
  assign count       = count_reg;
  assign entry_valid = valid_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_addr[gi] = addr_mem[gi];
  end
endmodule

// File: rtl/regfile_writeback.sv
// Module: regfile_writeback
// Write-back stage, sole driver of the register file write port. Merges
// single-cycle ALU results with one outstanding multi-cycle load, queues ALU
// results while a load return owns the port, and raises Stall whenever decode
// would read a register that still has a write in flight.
//  Clk   : clock, posedge
//  Reset : asynchronous, active-low
//  bus   : regfile_writeback_if.slave (ALU, load issue/return, hazard, RegFile)
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int W     = 8,
  parameter int A     = 2,
  parameter int DEPTH = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  regfile_writeback_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);

  wb_state_t              state_reg;
  logic [A-1:0]           pend_q;
  logic                   write_en_reg;
  logic [A-1:0]           waddr_reg;
  logic [W-1:0]           data_in_reg;

  logic [A-1:0]           q_head_addr;
  logic [W-1:0]           q_head_data;
  logic [CW-1:0]          q_count;
  logic [DEPTH-1:0][A-1:0] q_addr;
  logic [DEPTH-1:0]       q_valid;
  logic [DEPTH-1:0]       q_hit;

  logic    pending, load_ret, q_empty, alu_ready, alu_acc;
  logic    q_push, q_pop, pend_hit, wr_hit;
  wb_sel_t sel;

  assign pending  = (state_reg == WB_LOAD_PEND);
  assign load_ret = pending && bus.MemValid;
  assign q_empty  = (q_count == '0);

  // Registered count only; the address term keeps a younger ALU write to the
  // load's destination from landing before the load data.
  assign alu_ready = (q_count < CW'(DEPTH)) && !(pending && (bus.AluAddr == pend_q));
  assign alu_acc   = bus.AluValid && alu_ready;

  always_comb begin
    sel = SEL_NONE;
    if (load_ret)     sel = SEL_MEM;
    else if (!q_empty) sel = SEL_QUEUE;
    else if (alu_acc)  sel = SEL_ALU;
  end

  assign q_pop  = (sel == SEL_QUEUE);
  assign q_push = alu_acc && (sel != SEL_ALU);

  wb_queue #(.W(W), .A(A), .DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk         (Clk),
    .rst_n       (Reset),
    .push        (q_push),
    .push_addr   (bus.AluAddr),
    .push_data   (bus.AluData),
    .pop         (q_pop),
    .head_addr   (q_head_addr),
    .head_data   (q_head_data),
    .count       (q_count),
    .entry_addr  (q_addr),
    .entry_valid (q_valid)
  );

  // Hazard sources: pending load, every queued result, the write now on the port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign q_hit[gi] = q_valid[gi] && ((bus.RaddrA == q_addr[gi]) || (bus.RaddrB == q_addr[gi]));
  end
  assign pend_hit = pending && ((bus.RaddrA == pend_q) || (bus.RaddrB == pend_q));
  assign wr_hit   = write_en_reg && ((bus.RaddrA == waddr_reg) || (bus.RaddrB == waddr_reg));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= WB_IDLE;
      pend_q       <= '0;
      write_en_reg <= 1'b0;
      waddr_reg    <= '0;
      data_in_reg  <= '0;
    end else begin
      case (state_reg)
        WB_IDLE: begin
          if (bus.LdIssue) begin
            state_reg <= WB_LOAD_PEND;
            pend_q    <= bus.LdDest;
          end
        end
        WB_LOAD_PEND: begin
          // A coincident LdIssue is dropped; LdIssueReady is low here.
          if (bus.MemValid) state_reg <= WB_IDLE;
        end
        default: state_reg <= WB_IDLE;
      endcase

      case (sel)
        SEL_MEM: begin
          write_en_reg <= 1'b1;
          waddr_reg    <= pend_q;
          data_in_reg  <= bus.MemData;
        end
        SEL_QUEUE: begin
          write_en_reg <= 1'b1;
          waddr_reg    <= q_head_addr;
          data_in_reg  <= q_head_data;
        end
        SEL_ALU: begin
          write_en_reg <= 1'b1;
          waddr_reg    <= bus.AluAddr;
          data_in_reg  <= bus.AluData;
        end
        default: write_en_reg <= 1'b0;
      endcase
    end
  end

  assign bus.AluReady     = alu_ready;
  assign bus.LdIssueReady = (state_reg == WB_IDLE);
  assign bus.Stall        = pend_hit || wr_hit || (|q_hit);
  assign bus.WriteEn      = write_en_reg;
  assign bus.Waddr        = waddr_reg;
  assign bus.DataIn       = data_in_reg;
endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench: tb_regfile_writeback
// Drives directed scenarios followed by random traffic into regfile_writeback
// and compares every output, every cycle, against a transaction-level model:
// a list of queued ALU results, a pending-load record and the last write.
module tb_regfile_writeback;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  regfile_writeback_if #(.W(8), .A(2)) bus();

  regfile_writeback #(.W(8), .A(2), .DEPTH(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_pend;
  logic [1:0]  m_pend_a;
  logic [9:0]  m_q[$];
  bit          m_we;
  logic [1:0]  m_wa;
  logic [7:0]  m_wd;
  bit          m_in_reset;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_flight(input logic [1:0] r);
    bit h = 0;
    if (m_pend && r == m_pend_a) h = 1;
    foreach (m_q[i]) if (m_q[i][9:8] == r) h = 1;
    if (m_we && m_wa == r) h = 1;
    return h;
  endfunction

  function automatic void model_clear();
    m_pend = 0; m_pend_a = '0; m_q.delete();
    m_we = 0; m_wa = '0; m_wd = '0;
  endfunction

  // One clock cycle: drive, check outputs mid-cycle, advance the model.
  task automatic cycle(input bit av, input logic [1:0] aa, input logic [7:0] ad,
                       input bit li, input logic [1:0] ld,
                       input bit mv, input logic [7:0] md,
                       input logic [1:0] ra, input logic [1:0] rb);
    bit exp_rdy, acc, bypass, nwe;
    logic [1:0] nwa;
    logic [7:0] nwd;
    logic [9:0] e;
    bus.AluValid = av; bus.AluAddr = aa; bus.AluData = ad;
    bus.LdIssue = li;  bus.LdDest = ld;
    bus.MemValid = mv; bus.MemData = md;
    bus.RaddrA = ra;   bus.RaddrB = rb;
    #3;
    exp_rdy = (m_q.size() < 2) && !(m_pend && aa == m_pend_a);
    chk("AluReady", bus.AluReady, exp_rdy);
    chk("LdIssueReady", bus.LdIssueReady, !m_pend);
    chk("Stall", bus.Stall, in_flight(ra) || in_flight(rb));
    chk("WriteEn", bus.WriteEn, m_we);
    if (m_we || m_in_reset) begin
      chk("Waddr", bus.Waddr, m_wa);
      chk("DataIn", bus.DataIn, m_wd);
    end
    if (bus.WriteEn) $display("wr r%0d <= %02h", bus.Waddr, bus.DataIn);

    if (!m_in_reset) begin
      acc = av && exp_rdy;
      bypass = 0;
      nwe = 0; nwa = m_wa; nwd = m_wd;
      if (m_pend && mv) begin
        nwe = 1; nwa = m_pend_a; nwd = md;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        nwe = 1; nwa = e[9:8]; nwd = e[7:0];
      end else if (acc) begin
        nwe = 1; nwa = aa; nwd = ad; bypass = 1;
      end
      if (acc && !bypass) m_q.push_back({aa, ad});
      if (m_pend && mv) m_pend = 0;
      else if (!m_pend && li) begin m_pend = 1; m_pend_a = ld; end
      m_we = nwe; m_wa = nwa; m_wd = nwd;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] ra = 2'd0, input logic [1:0] rb = 2'd0);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  // Reset asserted off the clock edge; inputs stay busy to show they are ignored.
  task automatic reset_pulse(input int n);
    Reset = 1'b0;
    m_in_reset = 1;
    model_clear();
    repeat (n) cycle(1, 2'd1, 8'hEE, 1, 2'd1, 1, 8'hDD, 2'd1, 2'd2);
    Reset = 1'b1;
    m_in_reset = 0;
  endtask

  initial begin
    Reset = 1'b0;
    m_in_reset = 1;
    model_clear();
    idle(2);
    Reset = 1'b1;
    m_in_reset = 0;
    idle(1);

    // ALU bypass: one-cycle latency, then WriteEn drops.
    cycle(1, 2'd1, 8'h3C, 0, 0, 0, 0, 0, 0);
    idle(2, 2'd1);

    // Reset in the middle of a load; the late return must write nothing.
    cycle(0, 0, 0, 1, 2'd2, 0, 0, 2'd2, 0);
    idle(1, 2'd2);
    reset_pulse(2);
    cycle(0, 0, 0, 0, 0, 1, 8'h5A, 2'd2, 0);
    idle(2, 2'd2);

    // Load return owns the port while ALU results queue up and fill.
    cycle(0, 0, 0, 1, 2'd2, 0, 0, 0, 0);
    cycle(1, 2'd0, 8'h11, 0, 0, 1, 8'hA5, 2'd0, 2'd2);
    cycle(1, 2'd3, 8'h22, 1, 2'd1, 0, 0, 2'd3, 2'd0);
    cycle(1, 2'd0, 8'h33, 0, 0, 1, 8'h5B, 2'd1, 2'd3);
    cycle(1, 2'd2, 8'h44, 0, 0, 0, 0, 2'd0, 2'd2);
    cycle(1, 2'd2, 8'h44, 0, 0, 0, 0, 2'd0, 2'd2);
    idle(3, 2'd2, 2'd0);

    // WAW guard: ALU write to the pending load's register waits for the load.
    cycle(0, 0, 0, 1, 2'd2, 0, 0, 0, 0);
    repeat (3) cycle(1, 2'd2, 8'h77, 0, 0, 0, 0, 2'd2, 0);
    cycle(1, 2'd2, 8'h77, 0, 0, 1, 8'hC3, 2'd2, 0);
    cycle(1, 2'd2, 8'h77, 0, 0, 0, 0, 2'd2, 0);
    idle(2, 2'd2);

    // Stall on a pending load and on the write it produces; unrelated reads do not stall.
    cycle(0, 0, 0, 1, 2'd1, 0, 0, 2'd1, 0);
    idle(3, 2'd1);
    cycle(0, 0, 0, 0, 0, 1, 8'h9E, 2'd1, 2'd1);
    idle(2, 2'd1);
    cycle(0, 0, 0, 1, 2'd1, 0, 0, 2'd2, 2'd3);
    idle(2, 2'd2, 2'd3);
    cycle(0, 0, 0, 0, 0, 1, 8'h4D, 2'd2, 2'd3);
    idle(2, 2'd2, 2'd3);

    // LdIssue held high across a load, including the return cycle.
    cycle(0, 0, 0, 1, 2'd3, 0, 0, 2'd3, 0);
    cycle(0, 0, 0, 1, 2'd0, 0, 0, 2'd3, 0);
    cycle(0, 0, 0, 1, 2'd0, 1, 8'h61, 2'd3, 2'd0);
    cycle(0, 0, 0, 1, 2'd0, 0, 0, 2'd3, 2'd0);
    cycle(0, 0, 0, 0, 0, 1, 8'h62, 2'd3, 2'd0);
    idle(2, 2'd0, 2'd3);

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse(1);
      cycle(($urandom % 2) == 0, 2'($urandom), 8'($urandom),
            ($urandom % 4) == 0, 2'($urandom),
            ($urandom % 3) == 0, 8'($urandom),
            2'($urandom), 2'($urandom));
    end

    // Drain any outstanding load and queued results.
    cycle(0, 0, 0, 0, 0, 1, 8'hF0, 0, 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
